// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select, word-addressed instruction memory with a loader port.
// Optional build macro IF_STAGE_OOB_HALT_EN: fetch at or beyond the loaded word count behaves as HALT.
module if_stage #(
    parameter int PC_SIZE          = 32,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int MEM_DEPTH        = 256,
    parameter logic [INSTRUCTION_SIZE-1:0] HALT_INSTRUCTION = 32'hFFFF_FFFF,
    localparam int ADDR_W          = $clog2(MEM_DEPTH)
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic                        i_jump,
    input  logic [PC_SIZE-1:0]          i_jump_addr,
    input  logic                        i_branch,
    input  logic [PC_SIZE-1:0]          i_branch_addr,
    input  logic                        i_write_mem,
    input  logic [INSTRUCTION_SIZE-1:0] i_write_data,
    input  logic                        i_clear_mem,
    output logic [PC_SIZE-1:0]          o_pc,
    output logic [PC_SIZE-1:0]          o_next_seq_pc,
    output logic [INSTRUCTION_SIZE-1:0] o_instruction,
    output logic                        o_halt,
    output logic                        o_mem_full,
    output logic                        o_mem_empty,
    output logic [ADDR_W:0]             o_wr_ptr
);

    // state     | meaning
    // S_FETCH   | PC advances on enabled edges
    // S_HALTED  | HALT retired; PC frozen and NOP driven until reset
    typedef enum logic {S_FETCH, S_HALTED} state_t;

    logic [INSTRUCTION_SIZE-1:0] r_mem [MEM_DEPTH];
    logic [PC_SIZE-1:0]          r_pc;
    state_t                      r_state;
    logic [ADDR_W:0]             r_wr_ptr;

    logic [ADDR_W-1:0]           w_idx;
    logic [INSTRUCTION_SIZE-1:0] w_raw;
    logic [PC_SIZE-1:0]          w_next_seq;
    logic                        w_halted;
    logic                        w_oob;
    logic                        w_halt_fetch;
    logic                        w_full;
    logic                        w_wr_en;

    assign w_idx      = r_pc[ADDR_W+1:2];
    assign w_raw      = r_mem[w_idx];
    assign w_next_seq = r_pc + PC_SIZE'(4);
    assign w_halted   = (r_state == S_HALTED);

`ifdef IF_STAGE_OOB_HALT_EN
    assign w_oob = ({1'b0, w_idx} >= r_wr_ptr);
`else
    assign w_oob = 1'b0;
`endif

    // Raw compare happens before NOP forcing so IF/ID sees halt alongside the HALT word itself.
    assign w_halt_fetch = (w_raw == HALT_INSTRUCTION) | w_oob;

    assign o_pc          = r_pc;
    assign o_next_seq_pc = w_next_seq;
    assign o_instruction = (w_halted | w_oob) ? '0 : w_raw;
    assign o_halt        = w_halted | w_halt_fetch;

    assign w_full      = (r_wr_ptr == (ADDR_W+1)'(MEM_DEPTH));
    assign w_wr_en     = i_write_mem & ~i_clear_mem & ~w_full;
    assign o_mem_full  = w_full;
    assign o_mem_empty = (r_wr_ptr == '0);
    assign o_wr_ptr    = r_wr_ptr;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pc    <= '0;
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (i_enable) begin
                        if (i_jump) begin
                            r_pc <= i_jump_addr;
                        end else if (i_branch) begin
                            r_pc <= i_branch_addr;
                        end else if (w_halt_fetch) begin
                            r_state <= S_HALTED;
                        end else begin
                            r_pc <= w_next_seq;
                        end
                    end
                end
                default: begin
                    r_state <= S_HALTED;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
        end else if (i_clear_mem) begin
            r_wr_ptr <= '0;
        end else if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
        end
    end

    // Contents survive reset; reset only suppresses a write landing while it is asserted.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (i_reset && w_wr_en) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_write_data;
        end
    end

endmodule
